// File: rtl/bk_adder_pkg.sv
// Shared definitions for controllers that drive the mapped 12-bit Brent-Kung adder.
// The adder netlist takes its operands bit-interleaved: bus[2k]=a[k], bus[2k+1]=b[k].
package bk_adder_pkg;

  localparam int ADD_W = 12;

  typedef logic [ADD_W:0] add_res_t;

  function automatic logic [2*ADD_W-1:0] pack_add_in(input logic [ADD_W-1:0] a,
                                                     input logic [ADD_W-1:0] b);
    logic [2*ADD_W-1:0] v;
    v = '0;
    for (int k = 0; k < ADD_W; k++) begin
      v[2*k]   = a[k];
      v[2*k+1] = b[k];
    end
    return v;
  endfunction

  function automatic logic [ADD_W-1:0] unpack_add_a(input logic [2*ADD_W-1:0] v);
    logic [ADD_W-1:0] a;
    a = '0;
    for (int k = 0; k < ADD_W; k++) a[k] = v[2*k];
    return a;
  endfunction

  function automatic logic [ADD_W-1:0] unpack_add_b(input logic [2*ADD_W-1:0] v);
    logic [ADD_W-1:0] b;
    b = '0;
    for (int k = 0; k < ADD_W; k++) b[k] = v[2*k+1];
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// NREQ-wide round-robin arbiter: first asserted request at or above ptr_i, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  logic found;
  int   cand;

  always_comb begin
    found     = 1'b0;
    cand      = 0;
    gnt_idx_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_i[cand[IDW-1:0]]) begin
        found     = 1'b1;
        gnt_idx_o = cand[IDW-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
    assign gnt_o[gi] = found & (gnt_idx_o == IDW'(gi));
  end

endmodule

// File: rtl/bk_adder_arbiter.sv
// Round-robin front end sharing one external Brent-Kung adder among NREQ clients.
// Define BK_ADDER_ARB_RETIME_EN to add a MID register after the adder (3-cycle latency).
module bk_adder_arbiter
  import bk_adder_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ADD_W,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [2*W-1:0]    add_in,
  input  logic [W:0]        add_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W:0]        res_sum,
  output logic [IDW-1:0]    res_id
);

  logic            adv_res, adv_op, grant;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            op_valid_q, op_valid_d;
  logic [W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic            res_valid_q, res_valid_d;
  add_res_t        res_sum_q, res_sum_d;
  logic [IDW-1:0]  res_id_q, res_id_d;

  // What the RES stage loads from: OP directly, or the MID register when retimed.
  logic            feed_valid;
  add_res_t        feed_sum;
  logic [IDW-1:0]  feed_id;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*W +: W];
    assign b_arr[gi] = req_b[gi*W +: W];
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign adv_res = ~res_valid_q | res_ready;

`ifdef BK_ADDER_ARB_RETIME_EN
  logic            adv_mid;
  logic            mid_valid_q, mid_valid_d;
  add_res_t        mid_sum_q, mid_sum_d;
  logic [IDW-1:0]  mid_id_q, mid_id_d;

  assign adv_mid = ~mid_valid_q | adv_res;
  assign adv_op  = ~op_valid_q | adv_mid;

  always_comb begin
    mid_valid_d = mid_valid_q;
    mid_sum_d   = mid_sum_q;
    mid_id_d    = mid_id_q;
    if (adv_mid) begin
      mid_valid_d = op_valid_q;
      if (op_valid_q) begin
        mid_sum_d = add_out;
        mid_id_d  = op_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mid_valid_q <= 1'b0;
      mid_sum_q   <= '0;
      mid_id_q    <= '0;
    end else begin
      mid_valid_q <= mid_valid_d;
      mid_sum_q   <= mid_sum_d;
      mid_id_q    <= mid_id_d;
    end
  end

  assign feed_valid = mid_valid_q;
  assign feed_sum   = mid_sum_q;
  assign feed_id    = mid_id_q;
`else
  assign adv_op     = ~op_valid_q | adv_res;
  assign feed_valid = op_valid_q;
  assign feed_sum   = add_out;
  assign feed_id    = op_id_q;
`endif

  // Ready is masked during reset so nothing appears accepted on a cycle that is discarded.
  assign grant     = adv_op & ~rst & (|req_valid);
  assign req_ready = grant ? gnt : '0;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_id_d    = op_id_q;
    if (adv_op) begin
      op_valid_d = grant;
      if (grant) begin
        op_a_d   = a_arr[gnt_idx];
        op_b_d   = b_arr[gnt_idx];
        op_id_d  = gnt_idx;
        rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    if (adv_res) begin
      res_valid_d = feed_valid;
      if (feed_valid) begin
        res_sum_d = feed_sum;
        res_id_d  = feed_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      op_valid_q  <= op_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
    end
  end

  assign add_in    = pack_add_in(op_a_q, op_b_q);
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Bench for bk_adder_arbiter: directed cases plus random traffic against a queue-based model.
// The external adder is modelled behaviourally from the interleaved operand bus.
module tb_bk_adder_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int IDW  = 2;
`ifdef BK_ADDER_ARB_RETIME_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic [2*W-1:0]    add_in;
  logic [W:0]        add_out;
  logic              res_valid, res_ready;
  logic [W:0]        res_sum;
  logic [IDW-1:0]    res_id;

  always #5 clk = ~clk;

  bk_adder_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_in    (add_in),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
  );

  logic [W-1:0] ext_a, ext_b;
  always_comb begin
    ext_a = '0;
    ext_b = '0;
    for (int k = 0; k < W; k++) begin
      ext_a[k] = add_in[2*k];
      ext_b[k] = add_in[2*k+1];
    end
    add_out = {1'b0, ext_a} + {1'b0, ext_b};
  end

  typedef struct {
    logic [W:0] sum;
    int         id;
    int         acc;
  } item_t;

  item_t sb[$];
  int    ptr_m        = 0;
  int    cyc          = 0;
  int    tests_run    = 0;
  int    tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ilv(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] v;
    v = '0;
    for (int k = 0; k < W; k++) begin
      v[2*k]   = a[k];
      v[2*k+1] = b[k];
    end
    return v;
  endfunction

  // Reference: items leave in acceptance order; the head surfaces exactly DEPTH cycles
  // after acceptance; a new item is accepted unless DEPTH items wait on a stalled consumer.
  task automatic model_step();
    logic [NREQ-1:0] exp_rdy;
    logic            exp_valid;
    int              g;
    item_t           it;
    if (rst) begin
      check_eq("rst_ready", 32'(req_ready), 32'(0));
      sb.delete();
      ptr_m = 0;
      return;
    end
    exp_rdy = '0;
    g = -1;
    if (sb.size() < DEPTH || res_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (ptr_m + k) % NREQ;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    exp_valid = (sb.size() > 0) && (cyc >= sb[0].acc + DEPTH);
    check_eq("res_valid", 32'(res_valid), 32'(exp_valid));
    if (res_valid && exp_valid) begin
      check_eq("res_sum", 32'(res_sum), 32'(sb[0].sum));
      check_eq("res_id", 32'(res_id), 32'(sb[0].id));
      if (res_ready) begin
        $display("[TB] cyc=%0d result id=%0d sum=%0h", cyc, res_id, res_sum);
        void'(sb.pop_front());
      end
    end
    if (g >= 0) begin
      it.sum = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
      it.id  = g;
      it.acc = cyc;
      sb.push_back(it);
      ptr_m = (g + 1) % NREQ;
    end
  endtask

  task automatic tick();
    #2;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb.size() > 0; k++) begin
      req_valid = '0;
      res_ready = 1'b1;
      tick();
    end
    check_eq("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'($urandom);
      req_b[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic single_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W:0] exp_sum);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    res_ready = 1'b1;
    #1;
    check_eq("s_ready", 32'(req_ready), 32'(1 << idx));
    tick();
    req_valid = '0;
    #1;
    check_eq("s_add_in", 32'(add_in), 32'(ilv(a, b)));
    for (int k = 1; k < DEPTH; k++) begin
      check_eq("s_early", 32'(res_valid), 32'(0));
      tick();
    end
    check_eq("s_valid", 32'(res_valid), 32'(1));
    check_eq("s_sum", 32'(res_sum), 32'(exp_sum));
    check_eq("s_id", 32'(res_id), 32'(idx));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int start_ptr;
    int acc_cnt;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_res_valid", 32'(res_valid), 32'(0));
    check_eq("rst_res_sum", 32'(res_sum), 32'(0));
    check_eq("rst_res_id", 32'(res_id), 32'(0));
    check_eq("rst_add_in", 32'(add_in), 32'(0));

    single_op(0, 12'h123, 12'h456, 13'h0579);
    single_op(1, 12'hFFF, 12'h001, 13'h1000);
    single_op(3, 12'h800, 12'h800, 13'h1000);
    drain();

    // All requesters valid, consumer always ready: strict rotation.
    start_ptr = ptr_m;
    req_valid = '1;
    res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      #1;
      check_eq("rr_rot", 32'(req_ready), 32'(1 << ((start_ptr + k) % NREQ)));
      tick();
    end
    drain();

    // Consumer stalled: only DEPTH items fit before ready drops.
    acc_cnt = 0;
    req_valid = '1;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      #1;
      acc_cnt += $countones(req_ready);
      tick();
    end
    check_eq("bp_accepts", 32'(acc_cnt), 32'(DEPTH));
    drain();

    // Reset while full drops everything and rewinds the pointer.
    single_op(1, 12'h010, 12'h020, 13'h0030);
    req_valid = '1;
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '0;
    #1;
    check_eq("post_rst_valid", 32'(res_valid), 32'(0));
    single_op(2, 12'h0AB, 12'h0CD, 13'h0178);
    req_valid = '1;
    res_ready = 1'b1;
    #1;
    check_eq("post_rst_ptr", 32'(req_ready), 32'(1 << 3));
    tick();
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '1;
    #1;
    check_eq("rst_ptr_zero", 32'(req_ready), 32'(1));
    tick();
    drain();

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      req_valid = NREQ'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      rand_ops();
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bk_adder_arbiter.md
Name: bk_adder_arbiter

Overview:
- Shares one combinational 12-bit Brent-Kung adder netlist (24 interleaved operand inputs, 13 outputs) among NREQ requesters.
- Round-robin grant, valid/ready handshake per requester, registered operand stage driving the adder, registered result stage with requester ID and backpressure.
- Sits between client blocks and the single mapped adder instance. The adder is instantiated externally and connected through add_in/add_out.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 12, operand width; fixed to match adder netlist
- IDW, 2, requester ID width, equal to clog2(NREQ)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request valid per requester
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing as req_a
- req_ready  out  NREQ  one-hot accept; a transfer occurs when valid and ready are both high
- add_in  out  2*W  adder operand bus, interleaved: add_in[2k]=a[k], add_in[2k+1]=b[k]
- add_out  in  W+1  adder result: [W-1:0] sum, [W] carry-out
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_sum  out  W+1  {carry, sum}
- res_id  out  IDW  index of the requester that owns res_sum

Behaviour:
- Reset: req_ready=0, res_valid=0, res_sum=0, res_id=0, add_in=0, rr_ptr=0. All pipeline valid bits are cleared.
- Pipeline stage OP: registers op_valid, op_a, op_b, op_id. add_in is driven combinationally from op_a/op_b only, with no other logic.
- Pipeline stage RES: registers res_valid, res_sum, res_id.
- adv_res = ~res_valid | res_ready.
- adv_op = ~op_valid | adv_res.
- Arbitration, evaluated each cycle while adv_op is high:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ.
  - req_ready is one-hot to the granted requester. It is 0 for all requesters when adv_op=0 or no request is valid.
  - req_ready depends on req_valid combinationally; it never depends on a requester's ready.
- On grant: op_* loads {a, b, i}, op_valid=1, and rr_ptr becomes (i+1) mod NREQ. With no grant, op_valid loads 0 if adv_op is high.
- When adv_res is high and op_valid is high: res_sum<=add_out, res_id<=op_id, res_valid<=1.
- When adv_res is high and op_valid is low: res_valid<=0.
- When adv_res is low, RES holds and OP holds if it is occupied.
- Latency: accept in cycle N gives res_valid in cycle N+2.
- Throughput: one result per cycle while res_ready stays high.
- Backpressure:
  - res_ready low with RES full stalls RES.
  - OP keeps one item buffered while RES is stalled.
  - req_ready drops when both OP and RES are full.
  - No result is lost or duplicated.
- Arithmetic: res_sum = a + b, full 13-bit; carry-out lands in res_sum[12]. 0xFFF+0x001 gives 0x1000.
- rst asserted mid-operation drops all in-flight operations. No result is emitted for them, and the requester must resubmit.
- rr_ptr changes only on a grant.
- A single valid requester is granted every cycle it is valid and space exists.

Optional Feature:
- Macro: BK_ADDER_ARB_RETIME_EN.
- When defined: an extra register stage MID captures add_out and op_id between OP and RES.
  - MID is subject to the same advance rule chain: adv_mid = ~mid_valid | adv_res.
  - Latency becomes 3 cycles.
  - Up to 3 results are in flight.
- When undefined: the behaviour above, with 2-cycle latency.
- Port list and handshake semantics are identical in both builds.

Decomposition:
- Shared package bk_adder_pkg holds:
  - localparam ADD_W=12
  - the operand interleave/de-interleave functions (pack_add_in)
  - typedef add_res_t (13-bit)
- One natural sub-module: rr_arbiter (NREQ-wide round-robin, inputs req and ptr, outputs one-hot gnt and gnt_idx). It is reused by other shared-resource controllers.

Test Plan:
- Reset, then a single requester 0 issues a=0x123, b=0x456 with res_ready=1.
  - req_ready[0] is high in cycle 0.
  - res_valid in cycle 2 with res_sum=0x0579, res_id=0.
- Carry: a=0xFFF, b=0x001 → res_sum=0x1000. Also a=0x800, b=0x800 → res_sum=0x1000.
- All 4 requesters hold valid continuously with res_ready=1.
  - Grants rotate 0,1,2,3,0,…
  - res_id sequence matches the grant sequence, one result per cycle.
- res_ready held low for 5 cycles with all requesters valid.
  - Exactly 2 items are accepted, then req_ready=0.
  - After release, results drain in order with no drop or duplicate.
- rst pulsed one cycle while OP and RES are full.
  - Next cycle res_valid=0 and rr_ptr=0.
  - A new request from requester 2 yields res_id=2 two cycles later.
- With BK_ADDER_ARB_RETIME_EN, repeat scenario 1: res_valid in cycle 3 with the same value.
